branch_resolve_queue: RTL and testbench

In-order tracking queue for branch predictions in flight. It sits between fetch, which consumes `global_branch_predictor` predictions, and execute, which resolves branches. Fetch allocates one entry per predicted branch with its PC and history snapshot. On resolution the block produces the predictor write-back (load strobe, write PC, actual outcome), detects mispredictions, squashes younger wrong-path entries and supplies the corrected history value.

---
 rtl/branch_resolve_queue.sv | 159 +++++++++++++++
 tb/tb_branch_resolve_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Resolves the oldest entry,
// emits predictor write-back, squashes wrong-path entries on mispredict.
// Optional BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int BHR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [31:0]              alloc_pc,
  input  logic                     alloc_pred,
  input  logic [BHR_W-1:0]         alloc_bhr,
  output logic                     alloc_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [BHR_W-1:0]         restore_bhr,
  output logic [$clog2(DEPTH):0]   count
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]              stat_resolved,
  output logic [31:0]              stat_mispredicted
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      pc_mem_q   [DEPTH];
  logic             pred_mem_q [DEPTH];
  logic [BHR_W-1:0] bhr_mem_q  [DEPTH];

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             upd_valid_q, upd_valid_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [BHR_W-1:0] restore_bhr_q, restore_bhr_d;

  logic do_alloc, do_resolve, is_mis, mem_we;
  logic [31:0]      head_pc;
  logic             head_pred;
  logic [BHR_W-1:0] head_bhr;

  // Handshake: alloc is accepted when alloc_valid && alloc_ready (ready only
  // reflects the registered count); resolve always pops when the queue is
  // non-empty. Dropped requests leave no trace.
  assign alloc_ready = (count_q != CW'(DEPTH));
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_resolve  = resolve_valid && (count_q != '0);

  assign head_pc   = pc_mem_q[head_q];
  assign head_pred = pred_mem_q[head_q];
  assign head_bhr  = bhr_mem_q[head_q];
  assign is_mis    = do_resolve && (head_pred != resolve_taken);

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    upd_valid_d   = 1'b0;
    mispredict_d  = 1'b0;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    restore_bhr_d = restore_bhr_q;
    mem_we        = 1'b0;
    if (flush) begin
      tail_d  = head_q;
      count_d = '0;
    end else begin
      if (do_resolve) begin
        head_d        = head_q + PW'(1);
        upd_valid_d   = 1'b1;
        upd_pc_d      = head_pc;
        upd_taken_d   = resolve_taken;
        mispredict_d  = is_mis;
        restore_bhr_d = {head_bhr[BHR_W-2:0], resolve_taken};
      end
      if (is_mis) begin
        // Everything younger than the resolved branch is wrong-path.
        tail_d  = head_q + PW'(1);
        count_d = '0;
      end else begin
        mem_we  = do_alloc;
        tail_d  = tail_q + PW'(do_alloc);
        count_d = count_q + CW'(do_alloc) - CW'(do_resolve);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      restore_bhr_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      restore_bhr_q <= restore_bhr_d;
    end
  end

  // Entry storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem_q[tail_q]   <= alloc_pc;
      pred_mem_q[tail_q] <= alloc_pred;
      bhr_mem_q[tail_q]  <= alloc_bhr;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;
  assign restore_bhr = restore_bhr_q;
  assign count       = count_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (upd_valid_q && (stat_res_q != 32'hFFFF_FFFF)) stat_res_d = stat_res_q + 32'd1;
    if (mispredict_q && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved     = stat_res_q;
  assign stat_mispredicted = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a queue-based reference model
// predicts each write-back pulse; a monitor pops and compares.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int BHR_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 32 + 1 + 1 + BHR_W;

  typedef struct {
    logic [31:0]      pc;
    logic             pred;
    logic [BHR_W-1:0] bhr;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid, alloc_pred, resolve_valid, resolve_taken, flush;
  logic [31:0]      alloc_pc;
  logic [BHR_W-1:0] alloc_bhr;
  logic             alloc_ready, upd_valid, upd_taken, mispredict;
  logic [31:0]      upd_pc;
  logic [BHR_W-1:0] restore_bhr;
  logic [CW-1:0]    count;
`ifdef BRQ_STATS_EN
  logic [31:0]      stat_resolved, stat_mispredicted;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .BHR_W(BHR_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .alloc_bhr(alloc_bhr), .alloc_ready(alloc_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .mispredict(mispredict), .restore_bhr(restore_bhr), .count(count)
`ifdef BRQ_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispredicted(stat_mispredicted)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  entry_t          model_q[$];
  logic [W-1:0]    exp_q[$];
  int              errors = 0;
  int              checks = 0;
  int              n_upd = 0;
  int              n_mis = 0;

  // driver: compares occupancy, applies inputs, advances the reference model
  task automatic drive(input bit av, input logic [31:0] pc, input bit pred,
                       input logic [BHR_W-1:0] bhr, input bit rv, input bit tk,
                       input bit fl, input bit r);
    entry_t e;
    bit ready;
    @(negedge clk);
    checks++;
    if (count !== CW'(model_q.size())) begin
      errors++;
      $display("FAIL count: got %0d expected %0d at %0t", count, model_q.size(), $time);
    end
    ready = (model_q.size() != DEPTH);
    checks++;
    if (alloc_ready !== ready) begin
      errors++;
      $display("FAIL alloc_ready: got %b expected %b at %0t", alloc_ready, ready, $time);
    end
    rst = r; alloc_valid = av; alloc_pc = pc; alloc_pred = pred; alloc_bhr = bhr;
    resolve_valid = rv; resolve_taken = tk; flush = fl;
    if (r) begin
      model_q.delete();
      n_upd = 0;
      n_mis = 0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      bit mis = 1'b0;
      if (rv && model_q.size() > 0) begin
        e = model_q.pop_front();
        mis = (e.pred != tk);
        exp_q.push_back({e.pc, tk, mis, e.bhr[BHR_W-2:0], tk});
      end
      if (mis) model_q.delete();
      else if (av && ready) model_q.push_back('{pc, pred, bhr});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 0, '0, 0, 0, 0, 0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (upd_valid === 1'b1) begin
        n_upd++;
        if (mispredict === 1'b1) n_mis++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_upd: got upd_valid=1 pc=%h expected no pulse at %0t", upd_pc, $time);
        end else begin
          e = exp_q.pop_front();
          if ({upd_pc, upd_taken, mispredict, restore_bhr} !== e) begin
            errors++;
            $display("FAIL upd: got pc=%h tk=%b mis=%b bhr=%b expected pc=%h tk=%b mis=%b bhr=%b at %0t",
                     upd_pc, upd_taken, mispredict, restore_bhr,
                     e[W-1 -: 32], e[BHR_W+1], e[BHR_W], e[BHR_W-1:0], $time);
          end
        end
      end else begin
        checks++;
        if (mispredict !== 1'b0) begin
          errors++;
          $display("FAIL stray_mispredict: got %b expected 0 at %0t", mispredict, $time);
        end
        if (exp_q.size() != 0) begin
          checks++;
          errors++;
          e = exp_q.pop_front();
          $display("FAIL missing_upd: got upd_valid=%b expected pulse for pc=%h at %0t",
                   upd_valid, e[W-1 -: 32], $time);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1; alloc_valid = 0; alloc_pc = '0; alloc_pred = 0; alloc_bhr = '0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
    drive(0, 0, 0, '0, 0, 0, 0, 1);
    drive(0, 0, 0, '0, 0, 0, 0, 1);
    idle(10);

    // fill to DEPTH, overflow alloc dropped, drain in order
    for (int i = 0; i < 5; i++) drive(1, 32'h200 + 32'(i * 4), 1, 4'h5, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, '0, 1, 1, 0, 0);
    idle(2);

    // correct prediction
    drive(1, 32'h100, 1, 4'b1010, 0, 0, 0, 0);
    drive(0, 0, 0, '0, 1, 1, 0, 0);
    idle(2);

    // mispredict squash with a same-cycle alloc
    drive(1, 32'h100, 0, 4'b0011, 0, 0, 0, 0);
    drive(1, 32'h104, 1, 4'b0110, 0, 0, 0, 0);
    drive(1, 32'h108, 1, 4'b1101, 0, 0, 0, 0);
    drive(1, 32'h10c, 1, 4'b1111, 1, 1, 0, 0);
    idle(2);
    drive(1, 32'h300, 1, 4'h1, 0, 0, 0, 0);
    drive(0, 0, 0, '0, 1, 1, 0, 0);
    idle(1);

    // wrap-around at steady occupancy 2
    drive(1, 32'h400, 1, 4'h2, 0, 0, 0, 0);
    drive(1, 32'h404, 0, 4'h3, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      bit p = (i % 3) == 0;
      drive(1, 32'h408 + 32'(i * 4), p, 4'(i), 1, model_q[0].pred, 0, 0);
    end
    drive(0, 0, 0, '0, 1, model_q[0].pred, 0, 0);
    drive(0, 0, 0, '0, 1, model_q[0].pred, 0, 0);
    idle(1);

    // flush with concurrent resolve, then resolve on empty
    drive(1, 32'h500, 1, 4'h4, 0, 0, 0, 0);
    drive(1, 32'h504, 1, 4'h4, 0, 0, 0, 0);
    drive(1, 32'h508, 1, 4'h4, 1, 1, 1, 0);
    idle(1);
    drive(0, 0, 0, '0, 1, 1, 0, 0);
    idle(2);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      bit av = $urandom_range(0, 99) < 60;
      bit rv = $urandom_range(0, 99) < 50;
      bit pr = $urandom_range(0, 1);
      bit tk = (model_q.size() > 0 && $urandom_range(0, 99) < 85) ? model_q[0].pred
                                                                  : 1'($urandom_range(0, 1));
      bit fl = $urandom_range(0, 99) < 3;
      bit r  = $urandom_range(0, 199) == 0;
      drive(av, $urandom() & 32'hFFFF_FFFC, pr, BHR_W'($urandom()), rv, tk, fl, r);
    end
    drive(0, 0, 0, '0, 0, 0, 0, 1);
    drive(1, 32'h600, 1, 4'h9, 0, 0, 0, 0);
    drive(1, 32'h604, 0, 4'h9, 1, 0, 0, 0);
    drive(0, 0, 0, '0, 1, 0, 0, 0);
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
`ifdef BRQ_STATS_EN
    checks++;
    if (stat_resolved !== 32'(n_upd)) begin
      errors++;
      $display("FAIL stat_resolved: got %0d expected %0d", stat_resolved, n_upd);
    end
    checks++;
    if (stat_mispredicted !== 32'(n_mis)) begin
      errors++;
      $display("FAIL stat_mispredicted: got %0d expected %0d", stat_mispredicted, n_mis);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
